// File: rtl/rtype_encoder.sv
// Packs symbolic ALU operations into MIPS R-type words and streams them to
// consecutive instruction-memory addresses through a one-entry registered write port.
module rtype_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        aluop,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_ADDU = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_SUBU = 4'd4;
    localparam logic [3:0] ALU_AND  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLL  = 4'd9;
    localparam logic [3:0] ALU_SRL  = 4'd10;
    localparam logic [3:0] ALU_SRA  = 4'd11;

    localparam logic [ADDR_W:0] CAP    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CAP_M1 = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;

    state_t            state;
    logic [ADDR_W-1:0] next_addr;
    logic [5:0]        func;
    logic              legal;
    logic              is_shift;
    logic [31:0]       enc_word;
    logic              wr_hs;
    logic              accept;
    logic [ADDR_W:0]   committed;

    always_comb begin
        func     = 6'h00;
        legal    = 1'b1;
        is_shift = 1'b0;
        case (aluop)
            ALU_ADD:  func = 6'h20;
            ALU_ADDU: func = 6'h21;
            ALU_SUB:  func = 6'h22;
            ALU_SUBU: func = 6'h23;
            ALU_AND:  func = 6'h24;
            ALU_OR:   func = 6'h25;
            ALU_NOR:  func = 6'h27;
            ALU_SLT:  func = 6'h2A;
            ALU_SLL:  begin func = 6'h00; is_shift = 1'b1; end
            ALU_SRL:  begin func = 6'h02; is_shift = 1'b1; end
            ALU_SRA:  begin func = 6'h03; is_shift = 1'b1; end
            default:  legal = 1'b0;
        endcase
    end

    assign enc_word = {6'b0, (is_shift ? 5'd0 : rs), rt, rd,
                       (is_shift ? shamt : 5'd0), func};

    // Words written plus the one in flight; stop accepting once that fills memory.
    assign committed = count + {{ADDR_W{1'b0}}, wr_en};
    assign in_ready  = (state == RUN) && !start && (!wr_en || wr_ready)
                       && (committed != CAP);
    assign wr_hs     = wr_en && wr_ready;
    assign accept    = in_valid && in_ready;

    // next_addr advances when a word is loaded, so a load in the same cycle
    // as the pending write naturally targets the following address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            next_addr <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            count     <= '0;
            full      <= 1'b0;
            err       <= 1'b0;
        end else if (start) begin
            state     <= RUN;
            next_addr <= base_addr;
            wr_en     <= 1'b0;
            count     <= '0;
            full      <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (wr_hs) begin
                wr_en <= 1'b0;
                count <= count + 1'b1;
                if (count == CAP_M1) begin
                    state <= FULL;
                    full  <= 1'b1;
                end
            end
            if (accept) begin
                if (legal) begin
                    wr_en     <= 1'b1;
                    wr_addr   <= next_addr;
                    wr_data   <= enc_word;
                    next_addr <= next_addr + 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rtype_encoder.sv
// Scoreboard bench for rtype_encoder: expected writes are queued at acceptance
// and compared as each write handshake appears; a second 2-bit-address instance covers wrap and full.
module tb_rtype_encoder;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd8;
    localparam logic [3:0] OP_SLL = 4'd9;
    localparam logic [3:0] OP_SRA = 4'd11;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  aluop;
    logic [4:0]  rs, rt, rd, shamt;
    logic        wr_en;
    logic        wr_ready;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [8:0]  count;
    logic        full;
    logic        err;

    logic        s_start;
    logic [1:0]  s_base;
    logic        s_in_valid;
    logic        s_in_ready;
    logic        s_wr_en;
    logic        s_wr_ready;
    logic [1:0]  s_wr_addr;
    logic [31:0] s_wr_data;
    logic [2:0]  s_count;
    logic        s_full;
    logic        s_err;

    int n_chk  = 0;
    int n_pass = 0;

    logic [39:0] sb_q[$];
    logic [7:0]  exp_addr;

    always #5 clk = ~clk;

    rtype_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .aluop(aluop),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .count(count), .full(full), .err(err)
    );

    rtype_encoder #(.ADDR_W(2)) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .base_addr(s_base),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .aluop(aluop),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .wr_en(s_wr_en), .wr_ready(s_wr_ready), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .count(s_count), .full(s_full), .err(s_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] encode(input logic [3:0] op, input logic [4:0] a, b, c, d);
        logic [5:0] f;
        logic       sh;
        sh = 1'b0;
        case (op)
            4'd1:    f = 6'h20;
            4'd2:    f = 6'h21;
            4'd3:    f = 6'h22;
            4'd4:    f = 6'h23;
            4'd5:    f = 6'h24;
            4'd6:    f = 6'h25;
            4'd7:    f = 6'h27;
            4'd8:    f = 6'h2A;
            4'd9:    begin f = 6'h00; sh = 1'b1; end
            4'd10:   begin f = 6'h02; sh = 1'b1; end
            4'd11:   begin f = 6'h03; sh = 1'b1; end
            default: f = 6'h3F;
        endcase
        return {6'b0, (sh ? 5'd0 : a), b, c, (sh ? d : 5'd0), f};
    endfunction

    // Every write handshake on the wide instance must match the oldest queued word.
    always @(negedge clk) begin
        if (!rst && !start && wr_en && wr_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_write", {24'd0, wr_addr, wr_data}, 64'd0);
            end else begin
                logic [39:0] e;
                e = sb_q.pop_front();
                check("sb_addr", {56'd0, wr_addr}, {56'd0, e[39:32]});
                check("sb_data", {32'd0, wr_data}, {32'd0, e[31:0]});
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [4:0] a, b, c, d, input bit legal);
        bit ok;
        aluop = op; rs = a; rt = b; rd = c; shamt = d;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            if (legal) begin
                sb_q.push_back({exp_addr, encode(op, a, b, c, d)});
                exp_addr = exp_addr + 8'd1;
            end
            @(posedge clk); #1;
        end else begin
            check("send_timeout", 64'd0, 64'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] base);
        start = 1'b1;
        base_addr = base;
        sb_q.delete();
        exp_addr = base;
        @(negedge clk);
        check("start_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_in_ready"}, {63'd0, in_ready}, 64'd0);
        check({pfx, "_wr_en"},    {63'd0, wr_en},    64'd0);
        check({pfx, "_wr_addr"},  {56'd0, wr_addr},  64'd0);
        check({pfx, "_wr_data"},  {32'd0, wr_data},  64'd0);
        check({pfx, "_count"},    {55'd0, count},    64'd0);
        check({pfx, "_full"},     {63'd0, full},     64'd0);
        check({pfx, "_err"},      {63'd0, err},      64'd0);
    endtask

    task automatic drain();
        wr_ready = 1'b1;
        for (int i = 0; i < 10 && wr_en; i++) begin
            @(posedge clk); #1;
        end
        check("drain_done", {63'd0, wr_en}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  held_addr;
        logic [31:0] held_data;
        logic [8:0]  c0;

        rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        aluop = OP_NOP; rs = '0; rt = '0; rd = '0; shamt = '0; wr_ready = 1'b0;
        s_start = 1'b0; s_base = '0; s_in_valid = 1'b0; s_wr_ready = 1'b0;
        exp_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // First write, fixed encodings
        wr_ready = 1'b1;
        do_start(8'h10);
        send(OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 1'b1);
        @(negedge clk);
        check("add_wr_en", {63'd0, wr_en}, 64'd1);
        check("add_addr", {56'd0, wr_addr}, 64'h10);
        check("add_data", {32'd0, wr_data}, 64'h00221820);
        @(posedge clk); #1;
        @(negedge clk);
        check("add_count", {55'd0, count}, 64'd1);

        @(posedge clk); #1;
        send(OP_SLL, 5'd7, 5'd2, 5'd4, 5'd5, 1'b1);
        @(negedge clk);
        check("sll_data", {32'd0, wr_data}, 64'h00022140);
        @(posedge clk); #1;
        send(OP_SUB, 5'd1, 5'd2, 5'd3, 5'd9, 1'b1);
        @(negedge clk);
        check("sub_data", {32'd0, wr_data}, 64'h00221822);
        @(posedge clk); #1;
        drain();

        // Backpressure: word must hold while wr_ready is low
        wr_ready = 1'b0;
        send(OP_OR, 5'd4, 5'd5, 5'd6, 5'd0, 1'b1);
        @(negedge clk);
        held_addr = wr_addr;
        held_data = wr_data;
        for (int i = 0; i < 3; i++) begin
            check("stall_wr_en", {63'd0, wr_en}, 64'd1);
            check("stall_addr", {56'd0, wr_addr}, {56'd0, held_addr});
            check("stall_data", {32'd0, wr_data}, {32'd0, held_data});
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        wr_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            aluop = (k % 2 == 0) ? OP_SLT : OP_SRA;
            rs = 5'(k + 1); rt = 5'(k + 8); rd = 5'(k + 16); shamt = 5'(k + 3);
            in_valid = 1'b1;
            @(negedge clk);
            check("burst_in_ready", {63'd0, in_ready}, 64'd1);
            check("burst_wr_en", {63'd0, wr_en}, 64'd1);
            sb_q.push_back({exp_addr, encode(aluop, rs, rt, rd, shamt)});
            exp_addr = exp_addr + 8'd1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();

        // Illegal op: accepted, dropped, err sticky
        @(negedge clk);
        c0 = count;
        @(posedge clk); #1;
        send(OP_NOP, 5'd1, 5'd1, 5'd1, 5'd1, 1'b0);
        @(negedge clk);
        check("nop_err", {63'd0, err}, 64'd1);
        check("nop_wr_en", {63'd0, wr_en}, 64'd0);
        check("nop_count", {55'd0, count}, {55'd0, c0});
        @(posedge clk); #1;
        send(OP_ADD, 5'd9, 5'd10, 5'd11, 5'd0, 1'b1);
        drain();
        check("nop_err_sticky", {63'd0, err}, 64'd1);
        do_start(8'h80);
        @(negedge clk);
        check("start_clears_err", {63'd0, err}, 64'd0);
        @(posedge clk); #1;

        // start with a word pending and wr_ready high: discarded
        wr_ready = 1'b0;
        send(OP_ADD, 5'd2, 5'd3, 5'd4, 5'd0, 1'b1);
        wr_ready = 1'b1;
        do_start(8'h40);
        @(negedge clk);
        check("start_drop_wr_en", {63'd0, wr_en}, 64'd0);
        check("start_drop_count", {55'd0, count}, 64'd0);
        @(posedge clk); #1;
        send(OP_SUB, 5'd5, 5'd6, 5'd7, 5'd0, 1'b1);
        drain();
        check("post_start_count", {55'd0, count}, 64'd1);

        // Reset mid-stream
        wr_ready = 1'b0;
        send(OP_ADD, 5'd1, 5'd1, 5'd1, 5'd0, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        sb_q.delete();
        @(negedge clk);
        check_reset_vals("midrst");
        @(posedge clk); #1;
        rst = 1'b0;

        // Narrow instance: wrap-around and full
        aluop = OP_ADD; rs = 5'd1; rt = 5'd2; rd = 5'd3; shamt = 5'd0;
        s_wr_ready = 1'b1;
        s_start = 1'b1; s_base = 2'd3;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_in_valid = 1'b1;
            @(negedge clk);
            check("small_in_ready", {63'd0, s_in_ready}, 64'd1);
            @(posedge clk); #1;
            s_in_valid = 1'b0;
            @(negedge clk);
            check("small_wr_en", {63'd0, s_wr_en}, 64'd1);
            check("small_addr", {62'd0, s_wr_addr}, 64'((3 + i) % 4));
            check("small_data", {32'd0, s_wr_data}, 64'h00221820);
            @(posedge clk); #1;
        end
        s_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("small_full", {63'd0, s_full}, 64'd1);
            check("small_count", {61'd0, s_count}, 64'd4);
            check("small_full_in_ready", {63'd0, s_in_ready}, 64'd0);
            check("small_full_wr_en", {63'd0, s_wr_en}, 64'd0);
        end
        @(posedge clk); #1;
        s_in_valid = 1'b0;

        // Offer an input during the last handshake: must be refused
        s_start = 1'b1; s_base = 2'd0;
        @(posedge clk); #1;
        s_start = 1'b0;
        s_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("edge_in_ready", {63'd0, s_in_ready}, 64'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("edge_last_pending", {63'd0, s_wr_en}, 64'd1);
        check("edge_last_in_ready", {63'd0, s_in_ready}, 64'd0);
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        @(negedge clk);
        check("edge_full", {63'd0, s_full}, 64'd1);
        check("edge_count", {61'd0, s_count}, 64'd4);

        check("sb_empty_at_end", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rtype_encoder.md
# rtype_encoder

Sequential R-type instruction encoder, the inverse of the ID-stage controller. It accepts symbolic ALU operations with register/shift fields over a valid/ready handshake and packs them into 32-bit MIPS R-type words (opcode 0, func from the `FN_*` codes). It writes those words to consecutive instruction-memory word addresses through a one-entry registered write port with backpressure. It is used by the program loader and the self-test harness to fill instruction memory for the pipeline.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width; capacity is 2^ADDR_W words.
- `clk` input 1: clock, all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle pulse that arms the encoder at `base_addr`.
- `base_addr` input ADDR_W: first word address, sampled when `start`=1.
- `in_valid` input 1: operation request valid.
- `in_ready` output 1: request accepted when `in_valid & in_ready`.
- `aluop` input 4: `ALU_*` code from controller_constants.vh.
- `rs`, `rt`, `rd`, `shamt` input 5 each: instruction fields.
- `wr_en` output 1: write word valid, held until accepted.
- `wr_ready` input 1: memory accepts the write when `wr_en & wr_ready`.
- `wr_addr` output ADDR_W: word address.
- `wr_data` output 32: encoded instruction.
- `count` output ADDR_W+1: words written since the last `start`.
- `full` output 1: 2^ADDR_W words written; no further input is accepted.
- `err` output 1: sticky flag for an illegal `aluop`.

## Operation
- States:
  - IDLE (after reset).
  - RUN.
  - FULL.
- `start` in any state:
  - Go to RUN, set next address to `base_addr`, clear `count`, `full` and `err`.
  - Discard any pending `wr_en` word.
  - `in_ready`=0 in the `start` cycle.
- Encoding is `{6'b0, rs, rt, rd, shamt, func}`.
- `aluop`→func mapping:
  - ADD 0x20, ADDU 0x21, SUB 0x22, SUBU 0x23, AND 0x24, OR 0x25, NOR 0x27, SLT 0x2A.
  - SLL 0x00, SRL 0x02, SRA 0x03.
- Shifts (SLL/SRL/SRA): rs field forced to 0.
- Non-shifts: shamt field forced to 0.
- Illegal `aluop` (`ALU_NOP` or any unmapped code): the request is accepted and dropped. Set `err`. No write, address and `count` unchanged.
- Legal accepted request: load the output register, `wr_en`=1, `wr_addr`=next address.
- On write handshake:
  - next address increments by 1, wrapping modulo 2^ADDR_W.
  - `count`+1.
  - When `count` reaches 2^ADDR_W, go to FULL.
- `in_ready` = (state==RUN) & !start & (!wr_en | wr_ready).
  - A new request may be accepted in the same cycle the pending word is written (full throughput).
- In FULL, `in_ready`=0 until `start` or `rst`.
- While `wr_en`=1, `wr_addr`/`wr_data` must hold stable until the handshake.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0.
  - `count`=0, `full`=0, `err`=0.
- Latency: request accepted at edge N gives `wr_en`=1 with valid data after edge N; written at the first edge with `wr_ready`=1.
- Throughput: 1 word/cycle with `wr_ready` tied high.
- Last-word handshake:
  - `full`=1 and `in_ready`=0 from the next cycle.
  - An input offered in the same cycle as the 2^ADDR_W-th handshake is not accepted: `in_ready` is computed from the registered state, so it stays 1 only if fewer than 2^ADDR_W words remain after that write.
  - Implementation rule: `in_ready` is also 0 when `count` + `wr_en` = 2^ADDR_W.
- `rst` mid-stream overrides everything, including `start`. The pending word is lost and state returns to IDLE.
- `start` and `wr_ready` high together: `start` wins, the pending word is not written, and `count` ends at 0.

## Test plan
- Reset, then `start` with `base_addr`=0x10, then ADD rs=1 rt=2 rd=3 with `wr_ready`=1 → one cycle later `wr_en`=1, `wr_addr`=0x10, `wr_data`=0x00221820. Afterwards `count`=1.
- SLL rs=7 rt=2 rd=4 shamt=5 → `wr_data`=0x00022140 (rs zeroed). SUB rs=1 rt=2 rd=3 shamt=9 → 0x00221822 (shamt zeroed).
- `wr_ready`=0 for 3 cycles with a word pending → `wr_addr`/`wr_data` stable and `in_ready`=0. Then release → back-to-back writes at 1 word/cycle with no gap.
- `aluop`=`ALU_NOP` → `err`=1, no `wr_en`, `count` unchanged. The next ADD still writes at the same address. A subsequent `start` clears `err`.
- `ADDR_W`=2, `base_addr`=3, 4 ADDs → addresses 3,0,1,2. Then `full`=1, `count`=4, and a fifth `in_valid` is not accepted.
- `start` asserted while a word is pending and `wr_ready`=1 → no write occurs, `count`=0, and the next write goes to the new `base_addr`. `rst` mid-stream → all outputs return to reset values one edge later.
